// File: rtl/sync_fifo_lvl_pkg.sv
// Shared types and helpers for the level-flagged synchronous FIFO.
// The occupancy flags are derived from a single count so that they can never disagree.
package sync_fifo_lvl_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic fifo_flags_t derive_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned af_level,
                                               input int unsigned ae_level);
    fifo_flags_t f;
    f.empty        = (cnt == 0);
    f.full         = (cnt == depth);
    f.almost_empty = (cnt <= ae_level);
    f.almost_full  = (cnt >= af_level);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_lvl_ptr_wrap.sv
// Pointer advance with explicit wrap at DEPTH-1, so DEPTH need not be a power of two.
module fifo_ptr_wrap #(
  parameter int DEPTH = 16
) (
  input  logic [$clog2(DEPTH)-1:0] ptr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr_next
);

  localparam int PTR_W = $clog2(DEPTH);

  always_comb begin
    ptr_next = ptr;
    if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) ptr_next = '0;
      else                          ptr_next = ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with arbitrary depth, registered occupancy flags, sticky error flags,
// synchronous flush, and either first-word-fall-through or registered read data.
module sync_fifo_lvl
  import sync_fifo_lvl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int OUT_REG  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       we,
  input  logic [XLEN-1:0]            din,
  input  logic                       re,
  output logic [XLEN-1:0]            dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam fifo_flags_t FLAGS_RST = derive_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_lvl: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_lvl: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_lvl: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  fifo_flags_t      flags_reg, flags_next;
  logic             overflow_reg, underflow_reg;
  logic             active, wr_ok, rd_ok;

  // Nothing is accepted during reset or flush, so those cycles raise no error flags.
  assign active = ~reset & ~flush;
  assign wr_ok  = active & we & (~flags_reg.full | re);
  assign rd_ok  = active & re & ~flags_reg.empty;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .ptr      (wr_ptr_reg),
    .inc      (wr_ok),
    .ptr_next (wr_ptr_next)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .ptr      (rd_ptr_reg),
    .inc      (rd_ok),
    .ptr_next (rd_ptr_next)
  );

  always_comb begin
    count_next = count_reg + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    flags_next = derive_flags(int'(count_next), DEPTH, AF_LEVEL, AE_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      flags_reg     <= FLAGS_RST;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      flags_reg  <= flags_next;
      if (we && !wr_ok) overflow_reg  <= 1'b1;
      if (re && !rd_ok) underflow_reg <= 1'b1;
    end
  end

  // Storage is deliberately not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= din;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [XLEN-1:0] dout_reg;
    logic            dout_valid_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        dout_reg       <= '0;
        dout_valid_reg <= 1'b0;
      end else begin
        dout_valid_reg <= rd_ok;
        if (rd_ok) dout_reg <= mem[rd_ptr_reg];
      end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
  end else begin : g_fwft
    assign dout       = mem[rd_ptr_reg];
    assign dout_valid = ~flags_reg.empty;
  end

  assign empty        = flags_reg.empty;
  assign full         = flags_reg.full;
  assign almost_empty = flags_reg.almost_empty;
  assign almost_full  = flags_reg.almost_full;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Scoreboard bench: three FIFO instances (DEPTH 16 FWFT, DEPTH 5 FWFT, DEPTH 16 registered read).
module tb_sync_fifo_lvl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_flush, a_we, a_re, a_dv, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [7:0] a_din, a_dout;
  logic [4:0] a_count;

  logic       b_flush, b_we, b_re, b_dv, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_count;

  logic       c_flush, c_we, c_re, c_dv, c_empty, c_full, c_ae, c_af, c_ovf, c_udf;
  logic [7:0] c_din, c_dout;
  logic [4:0] c_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] c_q[$];
  bit a_ovf_m, a_udf_m;

  sync_fifo_lvl #(.XLEN(8), .DEPTH(16), .OUT_REG(0)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .we(a_we), .din(a_din), .re(a_re),
    .dout(a_dout), .dout_valid(a_dv), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf));

  sync_fifo_lvl #(.XLEN(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .OUT_REG(0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .we(b_we), .din(b_din), .re(b_re),
    .dout(b_dout), .dout_valid(b_dv), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf));

  sync_fifo_lvl #(.XLEN(8), .DEPTH(16), .OUT_REG(1)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .we(c_we), .din(c_din), .re(c_re),
    .dout(c_dout), .dout_valid(c_dv), .empty(c_empty), .full(c_full),
    .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
    .overflow(c_ovf), .underflow(c_udf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance A; FWFT data is checked before the edge, status after it.
  task automatic a_step(input bit we, input bit re, input bit fl, input logic [7:0] din);
    int n;
    bit wr_ok, rd_ok;
    logic [11:0] exp_v, act_v;
    a_we = we; a_re = re; a_flush = fl; a_din = din;
    n = a_q.size();
    if (fl) begin
      a_q.delete();
      a_ovf_m = 0;
      a_udf_m = 0;
    end else begin
      wr_ok = we && (n < 16 || re);
      rd_ok = re && (n > 0);
      if (rd_ok) begin
        logic [7:0] e;
        e = a_q.pop_front();
        total++;
        if (a_dout !== e) begin
          bad++;
          $display("FAIL a_rd_data: dout=%0h expected=%0h", a_dout, e);
        end else begin
          $display("a read  %02h", a_dout);
        end
      end
      if (wr_ok) a_q.push_back(din);
      if (we && !wr_ok) a_ovf_m = 1;
      if (re && !rd_ok) a_udf_m = 1;
    end
    tick();
    a_we = 0; a_re = 0; a_flush = 0;
    n = a_q.size();
    exp_v = {5'(n), n == 0, n == 16, n <= 2, n >= 14, a_ovf_m, a_udf_m, n != 0};
    act_v = {a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_udf, a_dv};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL a_status: {count,e,f,ae,af,ovf,udf,dv}=%b expected=%b", act_v, exp_v);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    a_flush = 0; a_we = 0; a_re = 0; a_din = 0;
    b_flush = 0; b_we = 0; b_re = 0; b_din = 0;
    c_flush = 0; c_we = 0; c_re = 0; c_din = 0;
    tick(); tick();
    reset = 0;
    total++;
    if ({a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_udf, a_dv} !== 12'b00000_1010000) begin
      bad++;
      $display("FAIL reset_a: got=%b expected=%b",
               {a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_udf, a_dv}, 12'b00000_1010000);
    end
    total++;
    if ({c_dout, c_dv, c_empty, c_count} !== {8'h00, 1'b0, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL reset_c: dout=%0h dv=%b empty=%b count=%0d expected 0/0/1/0",
               c_dout, c_dv, c_empty, c_count);
    end
    $display("reset done");
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) a_step(1, 0, 0, 8'(i));
    a_step(1, 0, 0, 8'hEE);
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) a_step(0, 1, 0, 8'h00);
    a_step(0, 1, 0, 8'h00);
  endtask

  task automatic test_flush_ignores_ops;
    a_step(1, 0, 0, 8'h01);
    a_step(1, 1, 1, 8'h77);
  endtask

  task automatic test_full_rw;
    for (int i = 1; i <= 16; i++) a_step(1, 0, 0, 8'(8'h30 + i));
    a_step(1, 1, 0, 8'hAA);
    for (int i = 0; i < 16; i++) a_step(0, 1, 0, 8'h00);
  endtask

  task automatic test_empty_rw;
    a_step(1, 1, 0, 8'h55);
    a_step(0, 1, 0, 8'h00);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) a_step(1, 0, 0, 8'(8'h90 + i));
    reset = 1; a_we = 1; a_din = 8'h99;
    tick();
    reset = 0; a_we = 0;
    a_q.delete(); a_ovf_m = 0; a_udf_m = 0;
    total++;
    if ({a_count, a_empty, a_ovf, a_udf} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid: count=%0d empty=%b ovf=%b udf=%b expected 0/1/0/0",
               a_count, a_empty, a_ovf, a_udf);
    end
    a_step(1, 0, 0, 8'h42);
    a_step(0, 1, 0, 8'h00);
  endtask

  task automatic test_wrap_depth5;
    for (int i = 0; i < 12; i++) begin
      b_we = 1; b_din = 8'(8'hC0 + i);
      b_q.push_back(b_din);
      tick();
      b_we = 0;
      total++;
      if (b_count !== 3'd1) begin
        bad++;
        $display("FAIL b_count_after_wr: count=%0d expected=1", b_count);
      end
      b_re = 1;
      begin
        logic [7:0] e;
        e = b_q.pop_front();
        total++;
        if (b_dout !== e) begin
          bad++;
          $display("FAIL b_rd_data: dout=%0h expected=%0h iter=%0d", b_dout, e, i);
        end else begin
          $display("b read  %02h", b_dout);
        end
      end
      tick();
      b_re = 0;
      total++;
      if ({b_empty, b_udf, b_ovf} !== 3'b100) begin
        bad++;
        $display("FAIL b_after_rd: {empty,udf,ovf}=%b expected=100", {b_empty, b_udf, b_ovf});
      end
    end
  endtask

  task automatic test_out_reg;
    logic [7:0] e;
    c_we = 1; c_din = 8'h11; c_q.push_back(8'h11); tick();
    c_din = 8'h22; c_q.push_back(8'h22); tick();
    c_we = 0;
    for (int k = 0; k < 2; k++) begin
      c_re = 1;
      tick();
      e = c_q.pop_front();
      total++;
      if ({c_dv, c_dout} !== {1'b1, e}) begin
        bad++;
        $display("FAIL c_rd_data: dv=%b dout=%0h expected dv=1 dout=%0h", c_dv, c_dout, e);
      end else begin
        $display("c read  %02h", c_dout);
      end
    end
    c_re = 0;
    tick();
    total++;
    if ({c_dv, c_dout} !== {1'b0, 8'h22}) begin
      bad++;
      $display("FAIL c_hold: dv=%b dout=%0h expected dv=0 dout=22", c_dv, c_dout);
    end
    c_re = 1;
    tick();
    c_re = 0;
    total++;
    if ({c_udf, c_dv, c_empty} !== 3'b101) begin
      bad++;
      $display("FAIL c_underflow: {udf,dv,empty}=%b expected=101", {c_udf, c_dv, c_empty});
    end
    for (int k = 0; k < 3; k++) begin
      c_we = 1; c_din = 8'(8'hE0 + k); tick();
    end
    c_we = 0;
    total++;
    if (c_count !== 5'd3) begin
      bad++;
      $display("FAIL c_count3: count=%0d expected=3", c_count);
    end
    c_flush = 1;
    tick();
    c_flush = 0;
    total++;
    if ({c_empty, c_count, c_ovf, c_udf, c_dv} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL c_flush: empty=%b count=%0d ovf=%b udf=%b dv=%b expected 1/0/0/0/0",
               c_empty, c_count, c_ovf, c_udf, c_dv);
    end
    c_we = 1; c_din = 8'h5A; c_q.push_back(8'h5A); tick();
    c_we = 0; c_re = 1; tick();
    c_re = 0;
    e = c_q.pop_front();
    total++;
    if ({c_dv, c_dout} !== {1'b1, e}) begin
      bad++;
      $display("FAIL c_post_flush: dv=%b dout=%0h expected dv=1 dout=%0h", c_dv, c_dout, e);
    end else begin
      $display("c read  %02h", c_dout);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_flush_ignores_ops();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    test_wrap_depth5();
    test_out_reg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
